// File: rtl/main_memory_arbiter_if.sv
// Requester-side and memory-port signals shared between the arbiter and its environment.
// Handshake: a request moves when req_valid[i] && req_ready[i] on the same clk edge; responses have no backpressure.
interface main_memory_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int WORD_BYTES = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_W-1:0]     req_address;
  logic [NUM_REQ*DATA_W-1:0]     req_wr_data;
  logic [NUM_REQ*WORD_BYTES-1:0] req_wr_en;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_W-1:0]             resp_rd_data;
  logic                          mem_reset;
  logic [ADDR_W-1:0]             mem_address;
  logic                          mem_rd_en;
  logic [DATA_W-1:0]             mem_wr_data;
  logic [WORD_BYTES-1:0]         mem_wr_en;
  logic [DATA_W-1:0]             mem_rd_data;

  modport slave (
    input  req_valid, req_address, req_wr_data, req_wr_en, mem_rd_data,
    output req_ready, resp_valid, resp_rd_data,
    output mem_reset, mem_address, mem_rd_en, mem_wr_data, mem_wr_en
  );

  modport master (
    output req_valid, req_address, req_wr_data, req_wr_en, mem_rd_data,
    input  req_ready, resp_valid, resp_rd_data,
    input  mem_reset, mem_address, mem_rd_en, mem_wr_data, mem_wr_en
  );
endinterface

// File: rtl/main_memory_arbiter.sv
// Round-robin arbiter sharing one main-memory port among NUM_REQ requesters.
// Read responses are routed back through a READ_LATENCY-deep {valid, index} pipeline.
module main_memory_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CAPACITY_BYTES = 4096,
  parameter int WORD_BYTES     = 4,
  parameter int READ_LATENCY   = 1
) (
  input logic clk,
  input logic reset,
  main_memory_arbiter_if.slave bus
);
  localparam int ADDR_W = $clog2(CAPACITY_BYTES);
  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      winner;
  logic [IDX_W-1:0]      hi_idx;
  logic [IDX_W-1:0]      lo_idx;
  logic                  hi_found;
  logic                  found;
  logic                  is_write;
  logic [NUM_REQ-1:0]    grant;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_data;
  logic [WORD_BYTES-1:0] sel_wr_en;
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [IDX_W-1:0]        pipe_idx [READ_LATENCY];
  logic                    out_valid;
  logic [IDX_W-1:0]        out_idx;

  // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_found = 1'b0;
    found    = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        found  = 1'b1;
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
    if (reset) found = 1'b0;
  end

  always_comb begin
    grant     = '0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_wr_en = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        grant[i]  = found;
        sel_addr  = bus.req_address[i*ADDR_W +: ADDR_W];
        sel_data  = bus.req_wr_data[i*DATA_W +: DATA_W];
        sel_wr_en = bus.req_wr_en[i*WORD_BYTES +: WORD_BYTES];
      end
    end
    is_write = |sel_wr_en;
  end

  assign bus.req_ready   = grant;
  assign bus.mem_reset   = reset;
  assign bus.mem_address = found ? sel_addr : '0;
  assign bus.mem_rd_en   = found & ~is_write;
  assign bus.mem_wr_en   = (found && is_write) ? sel_wr_en : '0;
  assign bus.mem_wr_data = (found && is_write) ? sel_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      pipe_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_idx[i] <= '0;
    end else begin
      if (found) ptr <= (winner == LAST) ? '0 : winner + 1'b1;
      pipe_valid[0] <= found & ~is_write;
      pipe_idx[0]   <= winner;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_idx[i]   <= pipe_idx[i-1];
      end
    end
  end

  assign out_valid = pipe_valid[READ_LATENCY-1];
  assign out_idx   = pipe_idx[READ_LATENCY-1];

  always_comb begin
    bus.resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (out_valid && out_idx == IDX_W'(i)) bus.resp_valid[i] = 1'b1;
    end
  end

  assign bus.resp_rd_data = out_valid ? bus.mem_rd_data : '0;
endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed bench for main_memory_arbiter: one READ_LATENCY=1 instance and one READ_LATENCY=2 instance,
// each backed by a small behavioural word memory.
module tb_main_memory_arbiter;
  localparam int NR = 4;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int WB = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_word;

  main_memory_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .WORD_BYTES(WB)) bus ();
  main_memory_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .WORD_BYTES(WB)) bus2 ();

  main_memory_arbiter #(.NUM_REQ(NR), .CAPACITY_BYTES(4096), .WORD_BYTES(WB), .READ_LATENCY(1)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  main_memory_arbiter #(.NUM_REQ(NR), .CAPACITY_BYTES(4096), .WORD_BYTES(WB), .READ_LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural memories: word array, byte-enable writes, registered read data
  logic [DW-1:0] mem  [1024];
  logic [DW-1:0] mem2 [1024];
  logic [DW-1:0] rd_q;
  logic [DW-1:0] rd2_p1;
  logic [DW-1:0] rd2_p2;
  logic          loaded;

  initial loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) begin
        mem[i]  = 32'hA000_0000 + i;
        mem2[i] = 32'hA000_0000 + i;
      end
      mem[4]  = 32'hDEAD_BEEF;
      mem2[4] = 32'hDEAD_BEEF;
      loaded <= 1'b1;
    end else begin
      if (bus.mem_rd_en) rd_q <= mem[bus.mem_address[11:2]];
      for (int b = 0; b < WB; b++)
        if (bus.mem_wr_en[b]) mem[bus.mem_address[11:2]][8*b +: 8] = bus.mem_wr_data[8*b +: 8];
      if (bus2.mem_rd_en) rd2_p1 <= mem2[bus2.mem_address[11:2]];
      rd2_p2 <= rd2_p1;
      for (int b = 0; b < WB; b++)
        if (bus2.mem_wr_en[b]) mem2[bus2.mem_address[11:2]][8*b +: 8] = bus2.mem_wr_data[8*b +: 8];
    end
  end

  assign bus.mem_rd_data  = rd_q;
  assign bus2.mem_rd_data = rd2_p2;

  // checking
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input int i, input logic v, input logic [AW-1:0] addr,
                         input logic [WB-1:0] we, input logic [DW-1:0] data);
    bus.req_valid[i]             = v;
    bus.req_address[i*AW +: AW]  = addr;
    bus.req_wr_en[i*WB +: WB]    = we;
    bus.req_wr_data[i*DW +: DW]  = data;
  endtask

  task automatic set_req2(input int i, input logic v, input logic [AW-1:0] addr);
    bus2.req_valid[i]            = v;
    bus2.req_address[i*AW +: AW] = addr;
    bus2.req_wr_en[i*WB +: WB]   = '0;
    bus2.req_wr_data[i*DW +: DW] = '0;
  endtask

  task automatic clear_reqs();
    bus.req_valid   = '0;
    bus.req_address = '0;
    bus.req_wr_en   = '0;
    bus.req_wr_data = '0;
    bus2.req_valid   = '0;
    bus2.req_address = '0;
    bus2.req_wr_en   = '0;
    bus2.req_wr_data = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    clear_reqs();

    // reset state: a pending request must not be granted while reset is high
    set_req(0, 1'b1, 12'h010, 4'b0000, 32'h0);
    @(negedge clk);
    check("rst_ready", bus.req_ready, 4'b0000);
    check("rst_rd_en", bus.mem_rd_en, 1'b0);
    check("rst_mem_reset", bus.mem_reset, 1'b1);
    check("rst_resp_valid", bus.resp_valid, 4'b0000);
    next_cycle();
    clear_reqs();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("idle_addr", bus.mem_address, 12'h000);
    check("idle_wr_en", bus.mem_wr_en, 4'b0000);
    check("idle_wr_data", bus.mem_wr_data, 32'h0);

    // single read by requester 1
    next_cycle();
    set_req(1, 1'b1, 12'h010, 4'b0000, 32'h0);
    @(negedge clk);
    check("t1_ready", bus.req_ready, 4'b0010);
    check("t1_rd_en", bus.mem_rd_en, 1'b1);
    check("t1_addr", bus.mem_address, 12'h010);
    check("t1_resp_early", bus.resp_valid, 4'b0000);
    next_cycle();
    clear_reqs();
    @(negedge clk);
    check("t1_resp_valid", bus.resp_valid, 4'b0010);
    check("t1_resp_data", bus.resp_rd_data, 32'hDEAD_BEEF);
    check("t1_ready_idle", bus.req_ready, 4'b0000);

    // read by requester 0 cut off by reset before its response
    next_cycle();
    set_req(0, 1'b1, 12'h010, 4'b0000, 32'h0);
    @(negedge clk);
    check("t4_ready", bus.req_ready, 4'b0001);
    next_cycle();
    clear_reqs();
    reset = 1'b1;
    @(negedge clk);
    check("t4_resp_valid", bus.resp_valid, 4'b0000);
    check("t4_resp_data", bus.resp_rd_data, 32'h0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("t4_resp_after", bus.resp_valid, 4'b0000);
    check("t4_rd_en", bus.mem_rd_en, 1'b0);
    check("t4_addr", bus.mem_address, 12'h000);

    // full load: pointer back at 0, so grants run 0,1,2,3,0,1,2,3
    next_cycle();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 12'(12'h100 + 4 * i), 4'b0000, 32'h0);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c < 8) begin
        check("t2_ready", bus.req_ready, 64'(4'b0001 << (c % 4)));
        check("t2_addr", bus.mem_address, 64'(12'h100 + 4 * (c % 4)));
        exp_q.push_back(32'hA000_0040 + 32'(c % 4));
      end
      if (c > 0) begin
        check("t2_resp_valid", bus.resp_valid, 64'(4'b0001 << ((c - 1) % 4)));
        exp_word = exp_q.pop_front();
        check("t2_resp_data", bus.resp_rd_data, exp_word);
      end else begin
        check("t2_resp_first", bus.resp_valid, 4'b0000);
      end
      next_cycle();
      if (c == 7) clear_reqs();
    end

    // requester 2 streams three reads back to back
    for (int k = 0; k < 4; k++) begin
      if (k < 3) set_req(2, 1'b1, 12'(4 * k), 4'b0000, 32'h0);
      else clear_reqs();
      @(negedge clk);
      if (k < 3) begin
        check("t5_ready", bus.req_ready, 4'b0100);
        check("t5_addr", bus.mem_address, 64'(4 * k));
      end
      if (k > 0) begin
        check("t5_resp_valid", bus.resp_valid, 4'b0100);
        check("t5_resp_data", bus.resp_rd_data, 64'(32'hA000_0000 + 32'(k - 1)));
      end
      next_cycle();
    end

    // write by requester 2 then read-back by requester 3, full word then low byte
    set_req(2, 1'b1, 12'h020, 4'b1111, 32'h1234_5678);
    @(negedge clk);
    check("t3_ready_wr", bus.req_ready, 4'b0100);
    check("t3_wr_en", bus.mem_wr_en, 4'b1111);
    check("t3_wr_data", bus.mem_wr_data, 32'h1234_5678);
    check("t3_rd_en_wr", bus.mem_rd_en, 1'b0);
    check("t3_addr_wr", bus.mem_address, 12'h020);
    next_cycle();
    clear_reqs();
    set_req(3, 1'b1, 12'h020, 4'b0000, 32'h0);
    @(negedge clk);
    check("t3_ready_rd", bus.req_ready, 4'b1000);
    check("t3_no_wr_resp", bus.resp_valid, 4'b0000);
    next_cycle();
    clear_reqs();
    set_req(2, 1'b1, 12'h020, 4'b0001, 32'h0000_00FF);
    @(negedge clk);
    check("t3_resp_valid", bus.resp_valid, 4'b1000);
    check("t3_resp_data", bus.resp_rd_data, 32'h1234_5678);
    check("t3_byte_wr_en", bus.mem_wr_en, 4'b0001);
    next_cycle();
    clear_reqs();
    set_req(3, 1'b1, 12'h020, 4'b0000, 32'h0);
    @(negedge clk);
    check("t3_ready_rd2", bus.req_ready, 4'b1000);
    next_cycle();
    clear_reqs();
    @(negedge clk);
    check("t3_byte_resp_valid", bus.resp_valid, 4'b1000);
    check("t3_byte_resp_data", bus.resp_rd_data, 32'h1234_56FF);

    // READ_LATENCY=2 instance: two simultaneous reads
    next_cycle();
    set_req2(0, 1'b1, 12'h010);
    set_req2(1, 1'b1, 12'h014);
    @(negedge clk);
    check("t6_ready_t", bus2.req_ready, 4'b0001);
    next_cycle();
    set_req2(0, 1'b0, 12'h000);
    @(negedge clk);
    check("t6_ready_t1", bus2.req_ready, 4'b0010);
    check("t6_resp_t1", bus2.resp_valid, 4'b0000);
    next_cycle();
    clear_reqs();
    @(negedge clk);
    check("t6_resp_t2", bus2.resp_valid, 4'b0001);
    check("t6_data_t2", bus2.resp_rd_data, 32'hDEAD_BEEF);
    next_cycle();
    @(negedge clk);
    check("t6_resp_t3", bus2.resp_valid, 4'b0010);
    check("t6_data_t3", bus2.resp_rd_data, 32'hA000_0005);
    next_cycle();
    @(negedge clk);
    check("t6_resp_t4", bus2.resp_valid, 4'b0000);
    check("t6_data_t4", bus2.resp_rd_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
